// File: rtl/sw_input_proc.sv
// PDU input front end: synchronizes and debounces 16 switches and two buttons,
// then turns accepted changes into one-cycle hex/add/del/set command pulses.

module sw_input_proc_deb #(
  parameter int W          = 16,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_new,
  output logic [W-1:0] o_deb,
  output logic         o_quiet,
  output logic         o_commit
);
  localparam int            CW      = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  r_s1, r_s2, r_s3, r_deb;
  logic [CW-1:0] r_cnt;
  logic          w_idle;

  // Count only while the synchronized value is steady and differs from the accepted one
  assign w_idle   = (r_s2 != r_s3) || (r_s2 == r_deb);
  assign o_commit = !w_idle && (r_cnt == CNT_MAX);
  assign o_new    = r_s2;
  assign o_deb    = r_deb;
  assign o_quiet  = (r_s2 == r_s3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_s3  <= '0;
      r_deb <= '0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_idle) begin
        r_cnt <= '0;
      end else if (o_commit) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module sw_input_proc #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] sw,
  input  logic        btn_del,
  input  logic        btn_set,
  output logic [3:0]  hex,
  output logic        add,
  output logic        del,
  output logic        set,
  output logic        ready
);
  localparam int            CW      = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_stab;

  logic [15:0] w_sw_new, w_sw_deb, w_sw_diff;
  logic        w_sw_quiet, w_sw_commit;
  logic        w_del_new, w_del_deb, w_del_quiet, w_del_commit;
  logic        w_set_new, w_set_deb, w_set_quiet, w_set_commit;
  logic        w_quiet, w_settled;
  logic [3:0]  w_low;

  sw_input_proc_deb #(.W(16), .DEB_CYCLES(DEB_CYCLES)) u_deb_sw (
    .clk(clk), .rstn(rstn), .i_raw(sw),
    .o_new(w_sw_new), .o_deb(w_sw_deb), .o_quiet(w_sw_quiet), .o_commit(w_sw_commit)
  );

  sw_input_proc_deb #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_del (
    .clk(clk), .rstn(rstn), .i_raw(btn_del),
    .o_new(w_del_new), .o_deb(w_del_deb), .o_quiet(w_del_quiet), .o_commit(w_del_commit)
  );

  sw_input_proc_deb #(.W(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .rstn(rstn), .i_raw(btn_set),
    .o_new(w_set_new), .o_deb(w_set_deb), .o_quiet(w_set_quiet), .o_commit(w_set_commit)
  );

  assign w_sw_diff = w_sw_new ^ w_sw_deb;
  assign w_quiet   = w_sw_quiet && w_del_quiet && w_set_quiet;
  // Don't leave INIT with a power-up value still waiting to be loaded
  assign w_settled = ((w_sw_diff == '0) || w_sw_commit) &&
                     ((w_del_new == w_del_deb) || w_del_commit) &&
                     ((w_set_new == w_set_deb) || w_set_commit);

  always_comb begin
    w_low = '0;
    for (int i = 15; i >= 0; i--)
      if (w_sw_diff[i]) w_low = 4'(i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_INIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_state == ST_INIT && w_quiet && r_stab == CNT_MAX && w_settled)
      w_next = ST_RUN;
  end

  always_comb begin
    ready = (r_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stab <= '0;
    end else if (!w_quiet) begin
      r_stab <= '0;
    end else if (r_stab != CNT_MAX) begin
      r_stab <= r_stab + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hex <= '0;
      add <= 1'b0;
      del <= 1'b0;
      set <= 1'b0;
    end else begin
      add <= 1'b0;
      del <= 1'b0;
      set <= 1'b0;
      if (r_state == ST_RUN) begin
        if (w_sw_commit) begin
          add <= 1'b1;
          hex <= w_low;
        end
        del <= w_del_commit && w_del_new;
        set <= w_set_commit && w_set_new;
      end
    end
  end
endmodule

// File: doc/sw_input_proc.md
Name: sw_input_proc

Overview:
- Front-end stage of the PDU input path. It turns 16 raw slide switches and two raw pushbuttons into clean one-cycle command pulses.
- It synchronizes and debounces every input, detects switch toggles and button presses, and encodes the toggled switch index as a hex digit.
- Its outputs drive the hex / add / del / set inputs of the PDU shift register directly, all in the 100 MHz clk domain.

Parameters:
- DEB_CYCLES, 1000000, cycles a synchronized input must stay stable before it is accepted (10 ms at 100 MHz). Legal range 2..2^24; bench uses 4.

Ports:
- clk  input  1  100 MHz system clock
- rstn  input  1  asynchronous active-low reset
- sw  input  16  raw slide switches, asynchronous to clk
- btn_del  input  1  raw delete pushbutton, active-high, asynchronous
- btn_set  input  1  raw set pushbutton, active-high, asynchronous
- hex  output  4  index of the toggled switch; valid while add=1, held otherwise
- add  output  1  one-cycle pulse: a switch toggle was accepted
- del  output  1  one-cycle pulse: btn_del press was accepted
- set  output  1  one-cycle pulse: btn_set press was accepted
- ready  output  1  high in RUN state (input baseline captured)

Behaviour:
- Reset (rstn=0, asynchronous):
  - hex=0, add=0, del=0, set=0, ready=0.
  - Synchronizer, debounced and counter registers all clear to 0.
  - FSM enters INIT.
  - Reset asserted mid-pulse kills the pulse immediately.
- Synchronizer: each of the 18 inputs passes through 2 flops (s1, s2), then a third "previous" flop (s3).
- Debounce, one group for sw[15:0] and one per button, each with its own counter:
  - If s2 != s3, or s2 == debounced value: counter <= 0.
  - Else if counter == DEB_CYCLES-1: debounced value <= s2, counter <= 0 (this is a "commit").
  - Else: counter increments.
  - Any change of any switch bit restarts the switch group's count.
  - Glitches shorter than DEB_CYCLES+1 stable cycles never commit.
- Latency: a raw change sampled at edge t0 and held stable commits at edge t0+DEB_CYCLES+2. The corresponding pulse is high for exactly the cycle that follows that edge.
- FSM states:
  - INIT:
    - Commits load the debounced registers silently; no pulses are generated.
    - Leave INIT once all three groups have had s2 == s3 for DEB_CYCLES consecutive cycles; ready <= 1.
    - Purpose: switches already on at power-up must not generate add.
  - RUN: commits generate pulses as below. The FSM never leaves RUN except on reset.
- Switch commit in RUN:
  - diff = old ^ new. If diff != 0: add <= 1 and hex <= index of the lowest set bit of diff.
  - Multiple bits changing in one commit produce one add with the lowest index; the others are absorbed.
  - Both on->off and off->on toggles count.
- Button commit in RUN:
  - A 0->1 commit gives a del (or set) pulse.
  - A 1->0 commit gives no pulse.
  - A held button gives exactly one pulse.
- Outputs are registered and independent. add, del and set may be asserted in the same cycle; priority is resolved downstream (set > add > del).
- hex holds its last value when add=0.

Test Plan:
- Reset with sw=16'h0081 and DEB_CYCLES=4 → ready rises about 7 cycles after rstn release. No add pulse at any time, and hex=0.
- In RUN, raise sw[5] at edge t0 and hold → add=1 and hex=4'h5 for exactly one cycle after edge t0+6. Then lower sw[5] → a second add with hex=4'h5.
- Toggle sw[9] for 3 cycles, then restore → no add. Toggle sw[3] and sw[12] in the same cycle and hold → one add with hex=4'h3.
- Bounce btn_set 1,0,1,0,1 at 1-cycle intervals, then hold high for 20 cycles, then release → exactly one set pulse, 6 cycles after the final rise. No pulse on release.
- Press btn_del and toggle sw[0] on the same edge → del=1 and add=1 with hex=0, in the same single cycle.
- Assert rstn=0 during an add pulse → add drops immediately. After release, ready returns low→high and no stale pulse appears.
